// File: rtl/adc_peak_cache.sv
// adc_peak_cache: per-channel windowed peak tracker for four 10-bit ADC streams, with a cached last-window peak and a selected-channel readout.
// Latency: the cache updates on the edge of the window-closing sample; Max_Value, Max_Valid and Sel_Error are registered 1 clk after a Channel_sel or cache change.
// Backpressure: none. Samples are always accepted, Hold only defers cache writes, and Clear discards everything. Optional build macro ADC_PEAK_ABS_EN selects magnitude-about-midscale peaks.
module adc_peak_cache #(
    parameter int WINDOW_LEN = 256,
    parameter int CNT_W      = 16
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic [9:0] Ch1_Data,
    input  logic [9:0] Ch2_Data,
    input  logic [9:0] Ch3_Data,
    input  logic [9:0] Ch4_Data,
    input  logic       Ch1_Ready,
    input  logic       Ch2_Ready,
    input  logic       Ch3_Ready,
    input  logic       Ch4_Ready,
    input  logic       Clear,
    input  logic       Hold,
    input  logic [2:0] Channel_sel,
    output logic [9:0] Max_Value,
    output logic       Max_Valid,
    output logic       Sel_Error,
    output logic [3:0] Window_Done
);

    // Counter value of the sample that closes a window.
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW_LEN - 1);

    // Gather the four channels into arrays so one generate body serves all of them.
    logic [9:0] data  [4];
    logic [3:0] ready;

    assign data[0] = Ch1_Data;
    assign data[1] = Ch2_Data;
    assign data[2] = Ch3_Data;
    assign data[3] = Ch4_Data;
    assign ready   = {Ch4_Ready, Ch3_Ready, Ch2_Ready, Ch1_Ready};

    // Per-channel results seen by the shared output stage.
    logic [9:0] cache [4];
    logic       valid [4];
    logic       done  [4];

    for (genvar g = 0; g < 4; g++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [9:0]       run_pk;
        logic [9:0]       pend_pk;
        logic             pend_flag;
        logic [9:0]       smp;
        logic [9:0]       win_pk;
        logic             close;

        // Map the raw word to the value being peaked: magnitude about midscale or raw code.
        always_comb begin
`ifdef ADC_PEAK_ABS_EN
            smp = (data[g] >= 10'd512) ? (data[g] - 10'd512) : (10'd512 - data[g]);
`else
            smp = data[g];
`endif
        end

        // The boundary sample is folded into the closing window's peak.
        assign close  = ready[g] && (cnt == LAST_IDX);
        assign win_pk = (smp > run_pk) ? smp : run_pk;

        // Window counter and running peak; Hold never stalls these.
        always_ff @(posedge clk or negedge reset_b) begin
            if (!reset_b) begin
                cnt    <= '0;
                run_pk <= '0;
            end else if (Clear) begin
                cnt    <= '0;
                run_pk <= '0;
            end else if (ready[g]) begin
                if (close) begin
                    cnt    <= '0;
                    run_pk <= '0;
                end else begin
                    cnt    <= cnt + CNT_W'(1);
                    run_pk <= win_pk;
                end
            end
        end

        // Cache write, deferred through the pending slot while Hold is high; a fresh window beats a stale pending one.
        always_ff @(posedge clk or negedge reset_b) begin
            if (!reset_b) begin
                cache[g]  <= '0;
                valid[g]  <= 1'b0;
                done[g]   <= 1'b0;
                pend_pk   <= '0;
                pend_flag <= 1'b0;
            end else if (Clear) begin
                cache[g]  <= '0;
                valid[g]  <= 1'b0;
                done[g]   <= 1'b0;
                pend_pk   <= '0;
                pend_flag <= 1'b0;
            end else begin
                done[g] <= 1'b0;
                if (close) begin
                    if (Hold) begin
                        pend_pk   <= win_pk;
                        pend_flag <= 1'b1;
                    end else begin
                        cache[g]  <= win_pk;
                        valid[g]  <= 1'b1;
                        done[g]   <= 1'b1;
                        pend_flag <= 1'b0;
                    end
                end else if (!Hold && pend_flag) begin
                    cache[g]  <= pend_pk;
                    valid[g]  <= 1'b1;
                    done[g]   <= 1'b1;
                    pend_flag <= 1'b0;
                end
            end
        end
    end

    assign Window_Done = {done[3], done[2], done[1], done[0]};

    // Registered readout of the selected channel; codes 4..7 report a select error.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            Max_Value <= '0;
            Max_Valid <= 1'b0;
            Sel_Error <= 1'b0;
        end else if (Channel_sel[2]) begin
            Max_Value <= '0;
            Max_Valid <= 1'b0;
            Sel_Error <= 1'b1;
        end else begin
            Max_Value <= cache[Channel_sel[1:0]];
            Max_Valid <= valid[Channel_sel[1:0]];
            Sel_Error <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_peak_cache.sv
// Bench for adc_peak_cache with a short window: directed scenarios, then random traffic.
// Each cycle's outputs are compared against a window-list reference model.
// The reference model follows the macro selection used for the RTL build.
module tb_adc_peak_cache;

    localparam int WL = 4;

    logic       clk = 1'b0;
    logic       reset_b;
    logic [9:0] d [4];
    logic [3:0] rdy;
    logic       clear;
    logic       hold;
    logic [2:0] sel;
    logic [9:0] Max_Value;
    logic       Max_Valid;
    logic       Sel_Error;
    logic [3:0] Window_Done;

    adc_peak_cache #(.WINDOW_LEN(WL), .CNT_W(16)) dut (
        .clk         (clk),
        .reset_b     (reset_b),
        .Ch1_Data    (d[0]),
        .Ch2_Data    (d[1]),
        .Ch3_Data    (d[2]),
        .Ch4_Data    (d[3]),
        .Ch1_Ready   (rdy[0]),
        .Ch2_Ready   (rdy[1]),
        .Ch3_Ready   (rdy[2]),
        .Ch4_Ready   (rdy[3]),
        .Clear       (clear),
        .Hold        (hold),
        .Channel_sel (sel),
        .Max_Value   (Max_Value),
        .Max_Valid   (Max_Valid),
        .Sel_Error   (Sel_Error),
        .Window_Done (Window_Done)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference state: samples of the open window, plus cached results.
    int       m_samp  [4][WL];
    int       m_n     [4];
    int       m_cache [4];
    bit       m_valid [4];
    int       m_pend  [4];
    bit       m_pflag [4];
    bit [3:0] m_done;
    int       m_val;
    bit       m_vld;
    bit       m_err;

    function automatic int mag(input int s);
`ifdef ADC_PEAK_ABS_EN
        return (s >= 512) ? s - 512 : 512 - s;
`else
        return s;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            m_n[c]     = 0;
            m_cache[c] = 0;
            m_valid[c] = 1'b0;
            m_pend[c]  = 0;
            m_pflag[c] = 1'b0;
        end
        m_done = 4'b0;
        m_val  = 0;
        m_vld  = 1'b0;
        m_err  = 1'b0;
    endtask

    // One clock edge of the reference, using the inputs present at that edge.
    task automatic model_edge();
        int pk;
        bit closed;
        if (sel < 3'd4) begin
            m_val = m_cache[sel[1:0]];
            m_vld = m_valid[sel[1:0]];
            m_err = 1'b0;
        end else begin
            m_val = 0;
            m_vld = 1'b0;
            m_err = 1'b1;
        end
        m_done = 4'b0;
        for (int c = 0; c < 4; c++) begin
            if (clear) begin
                m_n[c]     = 0;
                m_cache[c] = 0;
                m_valid[c] = 1'b0;
                m_pend[c]  = 0;
                m_pflag[c] = 1'b0;
            end else begin
                closed = 1'b0;
                pk     = 0;
                if (rdy[c]) begin
                    m_samp[c][m_n[c]] = mag(int'(d[c]));
                    m_n[c]++;
                    if (m_n[c] == WL) begin
                        for (int k = 0; k < WL; k++)
                            if (m_samp[c][k] > pk) pk = m_samp[c][k];
                        m_n[c] = 0;
                        closed = 1'b1;
                    end
                end
                if (closed) begin
                    if (hold) begin
                        m_pend[c]  = pk;
                        m_pflag[c] = 1'b1;
                    end else begin
                        m_cache[c] = pk;
                        m_valid[c] = 1'b1;
                        m_done[c]  = 1'b1;
                        m_pflag[c] = 1'b0;
                    end
                end else if (!hold && m_pflag[c]) begin
                    m_cache[c] = m_pend[c];
                    m_valid[c] = 1'b1;
                    m_done[c]  = 1'b1;
                    m_pflag[c] = 1'b0;
                end
            end
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".done"},  32'(Window_Done), 32'(m_done));
        chk({tag, ".value"}, 32'(Max_Value),   32'(m_val));
        chk({tag, ".valid"}, 32'(Max_Valid),   32'(m_vld));
        chk({tag, ".selerr"}, 32'(Sel_Error),  32'(m_err));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_outs(tag);
    endtask

    initial begin
        int t1 [4];
        int t2 [8];
        int t6 [4];
        int e;
        t1 = '{10, 700, 3, 5};
        t2 = '{300, 1, 2, 3, 200, 5, 6, 7};
        t6 = '{512, 0, 1023, 600};

        for (int c = 0; c < 4; c++) d[c] = 10'd0;
        rdy = 4'b0; clear = 1'b0; hold = 1'b0; sel = 3'd0;
        reset_b = 1'b0;
        model_reset();
        #2;
        check_outs("reset");
        #10;
        reset_b = 1'b1;
        step("idle");
        step("idle");

        // Single Ch1 window with the peak in the middle.
        sel = 3'd0;
        e = 0;
        for (int i = 0; i < 4; i++) begin
            d[0] = 10'(t1[i]); rdy = 4'b0001;
            if (mag(t1[i]) > e) e = mag(t1[i]);
            step("t1");
        end
        chk("t1_done_pulse", 32'(Window_Done), 32'd1);
        rdy = 4'b0;
        step("t1_read");
        chk("t1_max_value", 32'(Max_Value), 32'(e));
        chk("t1_max_valid", 32'(Max_Valid), 32'd1);
        for (int s = 1; s < 4; s++) begin
            sel = 3'(s);
            step("t1_other");
            chk("t1_other_invalid", 32'(Max_Valid), 32'd0);
        end

        // Two Ch2 windows under Hold; the later one must win on release.
        hold = 1'b1; sel = 3'd1;
        for (int i = 0; i < 8; i++) begin
            d[1] = 10'(t2[i]); rdy = 4'b0010;
            step("t2_hold");
            chk("t2_no_done_in_hold", 32'(Window_Done[1]), 32'd0);
        end
        e = 0;
        for (int i = 4; i < 8; i++) if (mag(t2[i]) > e) e = mag(t2[i]);
        rdy = 4'b0; hold = 1'b0;
        step("t2_release");
        chk("t2_release_done", 32'(Window_Done[1]), 32'd1);
        step("t2_read");
        chk("t2_latest_wins", 32'(Max_Value), 32'(e));
        chk("t2_single_pulse", 32'(Window_Done[1]), 32'd0);

        // Clear coincident with the closing Ch3 sample discards it.
        sel = 3'd2;
        for (int i = 0; i < 3; i++) begin
            d[2] = 10'(7 + i); rdy = 4'b0100;
            step("t3_fill");
        end
        d[2] = 10'd1000; rdy = 4'b0100; clear = 1'b1;
        step("t3_clear");
        chk("t3_clear_no_done", 32'(Window_Done[2]), 32'd0);
        clear = 1'b0; rdy = 4'b0;
        step("t3_after");
        chk("t3_cache_zero", 32'(Max_Value), 32'd0);
        chk("t3_invalid", 32'(Max_Valid), 32'd0);
        e = 0;
        for (int i = 1; i <= 4; i++) begin
            d[2] = 10'(i); rdy = 4'b0100;
            if (mag(i) > e) e = mag(i);
            step("t3_refill");
        end
        chk("t3_fresh_done", 32'(Window_Done[2]), 32'd1);
        rdy = 4'b0;
        step("t3_read");
        chk("t3_fresh_peak", 32'(Max_Value), 32'(e));

        // Out-of-range select.
        sel = 3'd5;
        step("t4_bad_sel");
        chk("t4_sel_error", 32'(Sel_Error), 32'd1);
        chk("t4_value_zero", 32'(Max_Value), 32'd0);
        chk("t4_valid_zero", 32'(Max_Valid), 32'd0);
        sel = 3'd0;
        step("t4_good_sel");
        chk("t4_sel_error_clear", 32'(Sel_Error), 32'd0);

        // All four channels strobed together.
        for (int n = 0; n < 4; n++) begin
            d[0] = 10'(n); d[1] = 10'(2 * n); d[2] = 10'(3 * n); d[3] = 10'(1023 - n);
            rdy = 4'b1111;
            step("t5_all");
        end
        chk("t5_all_done", 32'(Window_Done), 32'hF);
        rdy = 4'b0;
        for (int s = 0; s < 4; s++) begin
            sel = 3'(s);
            e = 0;
            for (int n = 0; n < 4; n++) begin
                int v;
                v = (s == 3) ? 1023 - n : (s + 1) * n;
                if (mag(v) > e) e = mag(v);
            end
            step("t5_read");
            chk("t5_cache", 32'(Max_Value), 32'(e));
        end

        // Midscale-sensitive window, then async reset mid-window.
        sel = 3'd0;
        e = 0;
        for (int i = 0; i < 4; i++) begin
            d[0] = 10'(t6[i]); rdy = 4'b0001;
            if (mag(t6[i]) > e) e = mag(t6[i]);
            step("t6");
        end
        rdy = 4'b0;
        step("t6_read");
        chk("t6_peak", 32'(Max_Value), 32'(e));
        for (int i = 0; i < 2; i++) begin
            d[0] = 10'd900; rdy = 4'b0001;
            step("t6_partial");
        end
        rdy = 4'b0;
        reset_b = 1'b0;
        #2;
        model_reset();
        check_outs("t6_async_reset");
        chk("t6_reset_valid", 32'(Max_Valid), 32'd0);
        @(posedge clk);
        #1;
        reset_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d[0] = 10'(50 + i); rdy = 4'b0001;
            step("t6_restart");
        end
        chk("t6_restart_done", 32'(Window_Done[0]), 32'd1);

        // Random traffic against the reference.
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < 4; c++) d[c] = 10'($urandom_range(0, 1023));
            rdy   = 4'($urandom);
            if ($urandom_range(0, 15) == 0) hold = ~hold;
            clear = ($urandom_range(0, 63) == 0);
            sel   = 3'($urandom_range(0, 7));
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adc_peak_cache.md
Name: adc_peak_cache

Overview:
- Sits between the four SPI ADC receivers and COMMAND_READER, which consumes Max_Value and drives Channel_sel.
- Tracks the running peak of each of the four 10-bit ADC channels over fixed-length sample windows.
- Caches the last completed window's peak per channel.
- Presents the selected channel's cached peak, registered, with a valid flag.

Parameters:
- WINDOW_LEN, 256: samples per channel per window; legal range 2..65535.
- CNT_W, 16: width of the per-channel window counters; must hold WINDOW_LEN-1.

Ports:
- clk  in  1  system clock.
- reset_b  in  1  asynchronous active-low reset.
- Ch1_Data, Ch2_Data, Ch3_Data, Ch4_Data  in  10 each  SPI sample words.
- Ch1_Ready, Ch2_Ready, Ch3_Ready, Ch4_Ready  in  1 each  one-clk sample strobes.
- Clear  in  1  synchronous clear of all running peaks, caches and counters.
- Hold  in  1  freeze cache updates while a read is in progress.
- Channel_sel  in  3  channel select: 0..3 map to Ch1..Ch4.
- Max_Value  out  10  cached peak of the selected channel.
- Max_Valid  out  1  selected channel has completed at least one window since the last reset or Clear.
- Sel_Error  out  1  Channel_sel > 3.
- Window_Done  out  4  one-clk pulse per channel when its cache updates.

Behaviour:
- Reset (async, reset_b low): all counters, running peaks, caches, pending registers and valid bits are 0. Outputs Max_Value=0, Max_Valid=0, Sel_Error=0, Window_Done=0.
- Per channel, independent and identical logic:
  - A sample is accepted on a rising clk edge where ChN_Ready=1.
  - run_pk <= max(run_pk, sample), compared unsigned.
  - cnt increments on each accepted sample.
  - On an accepted sample with cnt==WINDOW_LEN-1: win_pk = max(run_pk, sample); run_pk <= 0; cnt <= 0 (wrap).
  - The window boundary sample belongs to the closing window only.
- Cache update, Hold=0: cache <= win_pk, valid <= 1, Window_Done[N] pulses the same edge.
- Cache update, Hold=1:
  - win_pk goes into pend_pk; pend_flag <= 1; no Window_Done pulse.
  - A second window completing during Hold overwrites pend_pk, so the latest result wins.
- Hold falls, pend_flag=1:
  - First edge with Hold=0 moves pend_pk into the cache, clears pend_flag, sets valid and pulses Window_Done.
  - If a new window also completes on that edge, the new win_pk goes to the cache instead and pend is discarded.
- Clear=1: all per-channel state returns to reset values on that edge. A sample accepted on the same edge is discarded; Clear has priority.
- Output stage, registered with 1-clk latency from Channel_sel or a cache change:
  - Channel_sel 0..3: Max_Value <= cache[sel]; Max_Valid <= valid[sel]; Sel_Error <= 0.
  - Channel_sel 4..7: Max_Value <= 0; Max_Valid <= 0; Sel_Error <= 1.
- Simultaneous Ready strobes on several channels are all accepted on the same edge; there is no arbitration.
- Hold does not stall counting or run_pk; samples are never dropped except under Clear.
- reset_b asserted mid-window: window state is lost and counting restarts from 0 after release.

Optional Feature:
- Macro: ADC_PEAK_ABS_EN.
- Defined:
  - Samples are treated as offset-binary around midscale 512.
  - Compared value is |sample-512|: 0..512, stored in the same 10 bits.
  - Example: 0 maps to 512, 1023 maps to 511, 512 maps to 0.
  - run_pk, cache and Max_Value hold magnitudes.
- Undefined: raw unsigned sample peak as described above.
- Ports and timing are identical either way.

Test Plan:
1. WINDOW_LEN=4: Ch1 samples 10,700,3,5 -> on the 4th sample Window_Done[0]=1; with Channel_sel=0, Max_Value=700 and Max_Valid=1 one clk later. Ch2..Ch4 Max_Valid stay 0.
2. Hold=1 through two Ch2 windows with peaks 300 then 200, release Hold -> Ch2 cache=200 on the first Hold=0 edge; one Window_Done[1] pulse, none during Hold.
3. Clear asserted on the same edge as the 4th Ch3 sample (value 1000) -> Ch3 cache stays 0, Max_Valid=0, counter=0. The next 4 samples 1,2,3,4 give peak 4.
4. Channel_sel=5 -> Sel_Error=1, Max_Value=0, Max_Valid=0 one clk later. Channel_sel=0 -> Sel_Error=0 next clk.
5. All four Ready strobes every cycle, channel values n, 2n, 3n, 1023-n for n=0..3 -> caches 3, 6, 9, 1023 on the same edge; Window_Done=4'b1111.
6. ADC_PEAK_ABS_EN defined, Ch1 samples 512,0,1023,600 -> Max_Value=512. reset_b pulsed low mid-window -> all outputs 0 immediately, asynchronously.
